store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
//  Post-commit store buffer on the memory side of the store queue (sq). It accepts retired stores
//  (addr/value, one per cycle), holds them in program order and drains them to memory one at a
//  time with a command/response handshake. It also forwards data to younger loads whose
//  8-byte-aligned address matches a buffered store. Entries are architecturally committed and are
//  never squashed by thread1/thread2 mispredicts.
// PARAMETERS
//  WB_SIZE     8   number of entries; must be a power of two >= 2
//  BUS_NONE    0   proc2mem_command encoding: idle
//  BUS_STORE   2   proc2mem_command encoding: store request
// PORTS
//  clock              in   1                  system clock; all state updates on posedge
//  reset              in   1                  synchronous, active-high
//  sq_store_valid     in   1                  sq presents a committed store this cycle
//  sq_store_addr      in   64                 store byte address
//  sq_store_value     in   64                 store data
//  wb_full            out  1                  registered count == WB_SIZE (backpressure to sq)
//  wb_empty           out  1                  registered count == 0
//  wb_overflow        out  1                  sticky: store arrived while full
//  proc2mem_command   out  2                  BUS_STORE while in REQ, else BUS_NONE
//  proc2mem_addr      out  64                 head entry address in REQ, else 0
//  proc2mem_data      out  64                 head entry data in REQ, else 0
//  mem2proc_response  in   4                  nonzero = memory accepted current request
//  ld_addr            in   64                 load lookup address
//  ld_hit             out  1                  some valid entry matches ld_addr[63:3]
//  ld_data            out  64                 data of youngest matching entry, 0 if no hit
// BEHAVIOUR
//  - Storage: circular array with head/tail pointers of width $clog2(WB_SIZE) and a count of
//    width $clog2(WB_SIZE)+1. Pointers wrap modulo WB_SIZE.
//  - Reset: count=0, head=tail=0, state=IDLE, wb_overflow=0, all entries invalid. Outputs:
//    wb_empty=1, wb_full=0, proc2mem_*=0, ld_hit=0, ld_data=0.
//  - Enqueue: when sq_store_valid && !wb_full, write tail and advance tail on the next edge.
//    wb_full uses the registered count, so a same-cycle dequeue does NOT admit a store while full.
//  - sq_store_valid while wb_full: the store is dropped, the buffer is unchanged and wb_overflow
//    is set until reset.
//  - FSM IDLE: command=BUS_NONE. Go to REQ when registered count>0. The first request therefore
//    appears 1 cycle after the enqueue edge.
//  - FSM REQ: command=BUS_STORE, addr/data = head entry.
//    - response==0: stay in REQ; outputs stay stable.
//    - response!=0: pop head on this edge. Stay in REQ if count-1+enq > 0, else go to IDLE.
//      This gives back-to-back requests, one per cycle, while memory accepts every cycle.
//  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
//  - Forwarding (combinational, same cycle):
//    - Compares ld_addr[63:3] against all valid registered entries; the youngest match
//      (closest to tail) wins.
//    - A store being enqueued this cycle is not visible. An entry being popped this cycle is
//      still visible.
//  - Reset asserted mid-drain: all entries are discarded at the next edge; no request is issued
//    in the following cycle.
// TESTING
//  1 Reset 2 cycles -> wb_empty=1, wb_full=0, wb_overflow=0, command=0, ld_hit=0.
//  2 Enqueue addr 0xF1/value 0x0F.
//    - Next cycle: command=2, addr=0xF1, data=0x0F.
//    - Hold response=0 for 2 cycles: outputs stable.
//    - response=3: next cycle command=0, wb_empty=1.
//  3 Response held at 0, enqueue 8 stores: wb_full=1. A 9th store 0xDEAD: dropped,
//    wb_overflow=1, head data unchanged.
//  4 Enqueue 0x100/A, 0x108/B, 0x100/C (response 0).
//    - ld_addr=0x104 -> ld_hit=1, ld_data=C.
//    - ld_addr=0x10C -> B.
//    - ld_addr=0x110 -> ld_hit=0, ld_data=0.
//  5 Response fixed at 1, enqueue 12 stores on consecutive cycles: 12 requests in FIFO order,
//    one per cycle after the first, pointers wrap, and the buffer ends empty.
//  6 In REQ with 3 entries, assert reset 1 cycle -> next cycle wb_empty=1, command=0,
//    ld_hit=0, wb_overflow=0.

Source files
------------

// File: rtl/store_write_buffer.sv
// Post-commit store write buffer: holds retired stores in program order, drains them to memory
// one at a time over a command/response handshake, and forwards data to younger loads that hit
// an 8-byte-aligned buffered address.
module store_write_buffer #(
  parameter int unsigned WB_SIZE   = 8,
  parameter logic [1:0]  BUS_NONE  = 2'd0,
  parameter logic [1:0]  BUS_STORE = 2'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sq_store_valid,
  input  logic [63:0] sq_store_addr,
  input  logic [63:0] sq_store_value,
  output logic        wb_full,
  output logic        wb_empty,
  output logic        wb_overflow,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] ld_addr,
  output logic        ld_hit,
  output logic [63:0] ld_data
);

  localparam int unsigned PtrW = $clog2(WB_SIZE);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     head_q, head_d;
  logic [PtrW-1:0]     tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [WB_SIZE-1:0]  valid_q, valid_d;
  logic [63:0]         addr_q [WB_SIZE];
  logic [63:0]         data_q [WB_SIZE];

  logic                enq, deq;
  logic [PtrW-1:0]     fwd_idx;

  // Byte offset within the doubleword plays no part in forwarding.
  logic unused_ld_offset;
  assign unused_ld_offset = ^ld_addr[2:0];

  assign wb_full     = (count_q == CntW'(WB_SIZE));
  assign wb_empty    = (count_q == '0);
  assign wb_overflow = overflow_q;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign enq = sq_store_valid && !wb_full;
  assign deq = (state_q == StReq) && (mem2proc_response != 4'd0);

  // Pointer, count, validity and sticky-overflow next state.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q || (sq_store_valid && wb_full);
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  // Drain FSM next state and memory request outputs.
  always_comb begin
    state_d          = state_q;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StReq;
      end
      StReq: begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = addr_q[head_q];
        proc2mem_data    = data_q[head_q];
        // Last entry popped with nothing arriving behind it: go idle.
        if (deq && (count_q == CntW'(1)) && !enq) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load forwarding: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    for (int unsigned i = 0; i < WB_SIZE; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][63:3] == ld_addr[63:3])) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      addr_q[tail_q] <= sq_store_addr;
      data_q[tail_q] <= sq_store_value;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_store_write_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        sq_store_valid;
  logic [63:0] sq_store_addr;
  logic [63:0] sq_store_value;
  logic        wb_full, wb_empty, wb_overflow;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;

  // Reference model state
  logic [63:0] m_addr [$];
  logic [63:0] m_data [$];
  bit          m_req;
  bit          m_ovf;

  store_write_buffer dut (
    .clock             (clock),
    .reset             (reset),
    .sq_store_valid    (sq_store_valid),
    .sq_store_addr     (sq_store_addr),
    .sq_store_value    (sq_store_value),
    .wb_full           (wb_full),
    .wb_empty          (wb_empty),
    .wb_overflow       (wb_overflow),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .ld_addr           (ld_addr),
    .ld_hit            (ld_hit),
    .ld_data           (ld_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the model predicts for the current inputs.
  task automatic model_check();
    int          sz;
    logic        e_hit;
    logic [63:0] e_ld;
    sz    = m_addr.size();
    e_hit = 1'b0;
    e_ld  = '0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!e_hit && (m_addr[i][63:3] == ld_addr[63:3])) begin
        e_hit = 1'b1;
        e_ld  = m_data[i];
      end
    end
    chk("full",     {63'd0, wb_full},          {63'd0, sz == 8});
    chk("empty",    {63'd0, wb_empty},         {63'd0, sz == 0});
    chk("overflow", {63'd0, wb_overflow},      {63'd0, m_ovf});
    chk("command",  {62'd0, proc2mem_command}, m_req ? 64'd2 : 64'd0);
    chk("req_addr", proc2mem_addr,             m_req ? m_addr[0] : 64'd0);
    chk("req_data", proc2mem_data,             m_req ? m_data[0] : 64'd0);
    chk("ld_hit",   {63'd0, ld_hit},           {63'd0, e_hit});
    chk("ld_data",  ld_data,                   e_ld);
    if (proc2mem_command == 2'd2 && mem2proc_response != 4'd0) accepted++;
  endtask

  // Advance the model across one clock edge using the inputs the bench is driving.
  task automatic model_update();
    int sz;
    bit enq, deq;
    sz = m_addr.size();
    if (reset) begin
      m_addr.delete();
      m_data.delete();
      m_req = 1'b0;
      m_ovf = 1'b0;
    end else begin
      enq = sq_store_valid && (sz < 8);
      if (sq_store_valid && sz == 8) m_ovf = 1'b1;
      deq = m_req && (mem2proc_response != 4'd0);
      if (!m_req) m_req = (sz > 0);
      else if (deq) m_req = (sz - 1 + int'(enq)) > 0;
      if (deq) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
      end
      if (enq) begin
        m_addr.push_back(sq_store_addr);
        m_data.push_back(sq_store_value);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [63:0] a, input logic [63:0] d,
                       input logic [3:0] resp, input logic [63:0] la);
    @(negedge clock);
    reset             = rst;
    sq_store_valid    = v;
    sq_store_addr     = a;
    sq_store_value    = d;
    mem2proc_response = resp;
    ld_addr           = la;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
  endtask

  task automatic cyc(input logic rst, input logic v, input logic [63:0] a, input logic [63:0] d,
                     input logic [3:0] resp, input logic [63:0] la);
    drive(rst, v, a, d, resp, la);
    tick();
  endtask

  initial begin
    reset = 1'b1; sq_store_valid = 1'b0; sq_store_addr = '0; sq_store_value = '0;
    mem2proc_response = '0; ld_addr = '0;
    m_req = 1'b0; m_ovf = 1'b0;

    // 1: reset for two cycles, then idle outputs
    @(posedge clock); model_update();
    @(posedge clock); model_update();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'd0);
    chk("t1_empty", {63'd0, wb_empty}, 64'd1);
    chk("t1_cmd", {62'd0, proc2mem_command}, 64'd0);
    chk("t1_hit", {63'd0, ld_hit}, 64'd0);
    tick();

    // 2: single store, memory stalls two cycles then accepts
    cyc(1'b0, 1'b1, 64'hF1, 64'h0F, 4'd0, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 64'd0, 64'd0, (k == 2) ? 4'd3 : 4'd0, 64'd0);
      chk("t2_cmd", {62'd0, proc2mem_command}, 64'd2);
      chk("t2_addr", proc2mem_addr, 64'hF1);
      chk("t2_data", proc2mem_data, 64'h0F);
      tick();
    end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'd0);
    chk("t2_done_cmd", {62'd0, proc2mem_command}, 64'd0);
    chk("t2_done_empty", {63'd0, wb_empty}, 64'd1);
    tick();

    // 3: fill with response held low, then overflow
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 64'h40 + 64'(k * 8), 64'h1000 + 64'(k), 4'd0, 64'd0);
    drive(1'b0, 1'b1, 64'h900, 64'hDEAD, 4'd0, 64'd0);
    chk("t3_full", {63'd0, wb_full}, 64'd1);
    tick();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'h900);
    chk("t3_ovf", {63'd0, wb_overflow}, 64'd1);
    chk("t3_head", proc2mem_data, 64'h1000);
    chk("t3_dropped", {63'd0, ld_hit}, 64'd0);
    tick();
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 64'd0, 64'd0, 4'd1, 64'd0);

    // 4: forwarding picks the youngest aligned match
    cyc(1'b0, 1'b1, 64'h100, 64'hA, 4'd0, 64'd0);
    cyc(1'b0, 1'b1, 64'h108, 64'hB, 4'd0, 64'd0);
    cyc(1'b0, 1'b1, 64'h100, 64'hC, 4'd0, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'h104);
    chk("t4_hit_104", {63'd0, ld_hit}, 64'd1);
    chk("t4_data_104", ld_data, 64'hC);
    tick();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'h10C);
    chk("t4_data_10c", ld_data, 64'hB);
    tick();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'h110);
    chk("t4_hit_110", {63'd0, ld_hit}, 64'd0);
    chk("t4_data_110", ld_data, 64'd0);
    tick();
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 64'd0, 64'd0, 4'd1, 64'd0);

    // 5: memory always accepts, 12 back-to-back stores wrap the pointers
    accepted = 0;
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 64'h2000 + 64'(k * 8), 64'h50 + 64'(k), 4'd1, 64'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 64'd0, 64'd0, 4'd1, 64'd0);
    chk("t5_accepted", 64'(accepted), 64'd12);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd1, 64'd0);
    chk("t5_empty", {63'd0, wb_empty}, 64'd1);
    tick();

    // 6: reset in the middle of a drain
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 64'h300 + 64'(k * 8), 64'h70 + 64'(k), 4'd0, 64'd0);
    cyc(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'd0);
    cyc(1'b1, 1'b0, 64'd0, 64'd0, 4'd0, 64'h300);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 64'h300);
    chk("t6_empty", {63'd0, wb_empty}, 64'd1);
    chk("t6_cmd", {62'd0, proc2mem_command}, 64'd0);
    chk("t6_hit", {63'd0, ld_hit}, 64'd0);
    chk("t6_ovf", {63'd0, wb_overflow}, 64'd0);
    tick();

    // Random traffic against the model; small address pool so loads hit often
    for (int k = 0; k < 500; k++) begin
      logic        r_rst, r_v;
      logic [63:0] r_a, r_la;
      logic [3:0]  r_resp;
      r_rst  = ($urandom_range(0, 99) < 2);
      r_v    = ($urandom_range(0, 99) < 60);
      r_a    = 64'h4000 + 64'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
      r_la   = 64'h4000 + 64'($urandom_range(0, 8) * 8 + $urandom_range(0, 7));
      r_resp = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      cyc(r_rst, r_v, r_a, {32'd0, $urandom}, r_resp, r_la);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
